control_sequencer: RTL and testbench

//   Parametrised microsequencer for the 8-bit CPU datapath; next generation of the fixed 5-step controller.

---
 rtl/control_sequencer.sv | 157 +++++++++++++++
 tb/tb_control_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Microsequencer for the 8-bit CPU: decodes IR opcode and T-state into bus strobes,
// with early instruction termination, run/pause stepping and a sticky halt.
module control_sequencer #(
  parameter int OPCODE_W  = 4,
  parameter int T_STATES  = 6,
  parameter bit EARLY_END = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        run,
  input  logic [OPCODE_W-1:0]         opcode,
  input  logic                        flag_c,
  input  logic                        flag_z,
  output logic                        pc_enable,
  output logic                        pc_out,
  output logic                        pc_load,
  output logic                        mar_load,
  output logic                        ram_out,
  output logic                        ram_in,
  output logic                        ir_load,
  output logic                        ir_out,
  output logic                        reg_a_load,
  output logic                        reg_a_out,
  output logic                        reg_b_load,
  output logic                        alu_out,
  output logic                        alu_sub,
  output logic                        flags_load,
  output logic                        out_reg_load,
  output logic                        hlt,
  output logic                        instr_done,
  output logic [$clog2(T_STATES)-1:0] t_state
);

  localparam int TW = $clog2(T_STATES);

  if (T_STATES < 5) begin : g_t_states_check
    $error("control_sequencer: T_STATES must be >= 5");
  end

  localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_JC  = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_JZ  = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(14);
  localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(15);

  localparam logic [TW-1:0] T0   = TW'(0);
  localparam logic [TW-1:0] T1   = TW'(1);
  localparam logic [TW-1:0] T2   = TW'(2);
  localparam logic [TW-1:0] T3   = TW'(3);
  localparam logic [TW-1:0] T4   = TW'(4);
  localparam logic [TW-1:0] TMAX = TW'(T_STATES - 1);

  logic [TW-1:0] last_step;
  logic [TW-1:0] t_next;
  logic          hlt_next;
  logic          active;
  logic          wrap;

  // Gating with rst_n keeps strobes quiet while reset is asserted.
  assign active = rst_n && run && !hlt;

  always_comb begin
    case (opcode)
      OP_LDA, OP_STA:                               last_step = T3;
      OP_ADD, OP_SUB:                               last_step = T4;
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: last_step = T2;
      default:                                      last_step = T1;
    endcase
  end

  always_comb begin
    pc_enable    = 1'b0;
    pc_out       = 1'b0;
    pc_load      = 1'b0;
    mar_load     = 1'b0;
    ram_out      = 1'b0;
    ram_in       = 1'b0;
    ir_load      = 1'b0;
    ir_out       = 1'b0;
    reg_a_load   = 1'b0;
    reg_a_out    = 1'b0;
    reg_b_load   = 1'b0;
    alu_out      = 1'b0;
    alu_sub      = 1'b0;
    flags_load   = 1'b0;
    out_reg_load = 1'b0;
    instr_done   = 1'b0;
    if (active) begin
      instr_done = (t_state == last_step);
      if (t_state == T0) begin
        pc_out   = 1'b1;
        mar_load = 1'b1;
      end else if (t_state == T1) begin
        ram_out   = 1'b1;
        ir_load   = 1'b1;
        pc_enable = 1'b1;
      end else begin
        // Steps past an opcode's last active step fall through with no strobes.
        case (opcode)
          OP_LDA: begin
            if (t_state == T2) begin ir_out = 1'b1;  mar_load   = 1'b1; end
            if (t_state == T3) begin ram_out = 1'b1; reg_a_load = 1'b1; end
          end
          OP_ADD, OP_SUB: begin
            if (t_state == T2) begin ir_out = 1'b1;  mar_load   = 1'b1; end
            if (t_state == T3) begin ram_out = 1'b1; reg_b_load = 1'b1; end
            if (t_state == T4) begin
              alu_out    = 1'b1;
              reg_a_load = 1'b1;
              flags_load = 1'b1;
              alu_sub    = (opcode == OP_SUB);
            end
          end
          OP_STA: begin
            if (t_state == T2) begin ir_out = 1'b1;    mar_load = 1'b1; end
            if (t_state == T3) begin reg_a_out = 1'b1; ram_in   = 1'b1; end
          end
          OP_LDI: if (t_state == T2) begin ir_out = 1'b1; reg_a_load = 1'b1; end
          OP_JMP: if (t_state == T2) begin ir_out = 1'b1; pc_load = 1'b1; end
          OP_JC:  if (t_state == T2 && flag_c) begin ir_out = 1'b1; pc_load = 1'b1; end
          OP_JZ:  if (t_state == T2 && flag_z) begin ir_out = 1'b1; pc_load = 1'b1; end
          OP_OUT: if (t_state == T2) begin reg_a_out = 1'b1; out_reg_load = 1'b1; end
          default: ;
        endcase
      end
    end
  end

  // The >= compares recover cleanly if the opcode changes mid-instruction.
  assign wrap = EARLY_END ? ((t_state >= last_step) || (t_state >= TMAX))
                          : (t_state >= TMAX);

  always_comb begin
    t_next   = t_state;
    hlt_next = hlt;
    if (run && !hlt) begin
      t_next = wrap ? T0 : t_state + TW'(1);
      if (opcode == OP_HLT && t_state == T2) hlt_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_state <= '0;
      hlt     <= 1'b0;
    end else begin
      t_state <= t_next;
      hlt     <= hlt_next;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: expected step results are queued as stimulus
// is driven and compared when the step's outputs are sampled on the falling edge.
module tb_control_sequencer;

  localparam logic [14:0] PC_ENABLE    = 15'h4000;
  localparam logic [14:0] PC_OUT       = 15'h2000;
  localparam logic [14:0] PC_LOAD      = 15'h1000;
  localparam logic [14:0] MAR_LOAD     = 15'h0800;
  localparam logic [14:0] RAM_OUT      = 15'h0400;
  localparam logic [14:0] RAM_IN       = 15'h0200;
  localparam logic [14:0] IR_LOAD      = 15'h0100;
  localparam logic [14:0] IR_OUT       = 15'h0080;
  localparam logic [14:0] REG_A_LOAD   = 15'h0040;
  localparam logic [14:0] REG_A_OUT    = 15'h0020;
  localparam logic [14:0] REG_B_LOAD   = 15'h0010;
  localparam logic [14:0] ALU_OUT      = 15'h0008;
  localparam logic [14:0] ALU_SUB      = 15'h0004;
  localparam logic [14:0] FLAGS_LOAD   = 15'h0002;
  localparam logic [14:0] OUT_REG_LOAD = 15'h0001;
  localparam logic [14:0] NONE         = 15'h0000;
  localparam logic [14:0] F0           = PC_OUT | MAR_LOAD;
  localparam logic [14:0] F1           = RAM_OUT | IR_LOAD | PC_ENABLE;

  typedef struct {
    bit          dut;
    logic [2:0]  t;
    logic [14:0] s;
    logic        done;
    logic        hlt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic       clk = 1'b0;
  logic       rst_n, run, flag_c, flag_z;
  logic [3:0] opcode;
  wire [14:0] s0, s1;
  wire [2:0]  t0, t1;
  wire        done0, done1, hlt0, hlt1;

  always #5 clk = ~clk;

  control_sequencer #(.OPCODE_W(4), .T_STATES(6), .EARLY_END(1'b1)) dut_early (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .flag_c(flag_c), .flag_z(flag_z),
    .pc_enable(s0[14]), .pc_out(s0[13]), .pc_load(s0[12]), .mar_load(s0[11]),
    .ram_out(s0[10]), .ram_in(s0[9]), .ir_load(s0[8]), .ir_out(s0[7]),
    .reg_a_load(s0[6]), .reg_a_out(s0[5]), .reg_b_load(s0[4]), .alu_out(s0[3]),
    .alu_sub(s0[2]), .flags_load(s0[1]), .out_reg_load(s0[0]),
    .hlt(hlt0), .instr_done(done0), .t_state(t0)
  );

  control_sequencer #(.OPCODE_W(4), .T_STATES(6), .EARLY_END(1'b0)) dut_full (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .flag_c(flag_c), .flag_z(flag_z),
    .pc_enable(s1[14]), .pc_out(s1[13]), .pc_load(s1[12]), .mar_load(s1[11]),
    .ram_out(s1[10]), .ram_in(s1[9]), .ir_load(s1[8]), .ir_out(s1[7]),
    .reg_a_load(s1[6]), .reg_a_out(s1[5]), .reg_b_load(s1[4]), .alu_out(s1[3]),
    .alu_sub(s1[2]), .flags_load(s1[1]), .out_reg_load(s1[0]),
    .hlt(hlt1), .instr_done(done1), .t_state(t1)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Queue one step's expectation, sample on the falling edge, then move past the next rising edge.
  task automatic cyc(input bit which, input logic [2:0] et, input logic [14:0] es,
                     input logic ed, input logic eh, input string tag);
    exp_t e;
    sb.push_back('{which, et, es, ed, eh});
    @(negedge clk);
    e = sb.pop_front();
    if (e.dut) begin
      chk({tag, ".t_state"}, 16'(t1), 16'(e.t));
      chk({tag, ".strobes"}, 16'(s1), 16'(e.s));
      chk({tag, ".instr_done"}, 16'(done1), 16'(e.done));
      chk({tag, ".hlt"}, 16'(hlt1), 16'(e.hlt));
    end else begin
      chk({tag, ".t_state"}, 16'(t0), 16'(e.t));
      chk({tag, ".strobes"}, 16'(s0), 16'(e.s));
      chk({tag, ".instr_done"}, 16'(done0), 16'(e.done));
      chk({tag, ".hlt"}, 16'(hlt0), 16'(e.hlt));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b1; opcode = 4'h1; flag_c = 1'b0; flag_z = 1'b0;
    cyc(0, 3'd0, NONE, 1'b0, 1'b0, "reset");
    rst_n = 1'b1;

    cyc(0, 3'd0, F0, 1'b0, 1'b0, "lda_t0");
    cyc(0, 3'd1, F1, 1'b0, 1'b0, "lda_t1");
    cyc(0, 3'd2, IR_OUT | MAR_LOAD, 1'b0, 1'b0, "lda_t2");
    cyc(0, 3'd3, RAM_OUT | REG_A_LOAD, 1'b1, 1'b0, "lda_t3");

    opcode = 4'h2;
    cyc(0, 3'd0, F0, 1'b0, 1'b0, "add_t0");
    cyc(0, 3'd1, F1, 1'b0, 1'b0, "add_t1");
    cyc(0, 3'd2, IR_OUT | MAR_LOAD, 1'b0, 1'b0, "add_t2");
    cyc(0, 3'd3, RAM_OUT | REG_B_LOAD, 1'b0, 1'b0, "add_t3");
    cyc(0, 3'd4, ALU_OUT | REG_A_LOAD | FLAGS_LOAD, 1'b1, 1'b0, "add_t4");

    opcode = 4'h3;
    cyc(0, 3'd0, F0, 1'b0, 1'b0, "sub_t0");
    cyc(0, 3'd1, F1, 1'b0, 1'b0, "sub_t1");
    cyc(0, 3'd2, IR_OUT | MAR_LOAD, 1'b0, 1'b0, "sub_t2");
    cyc(0, 3'd3, RAM_OUT | REG_B_LOAD, 1'b0, 1'b0, "sub_t3");
    cyc(0, 3'd4, ALU_OUT | REG_A_LOAD | FLAGS_LOAD | ALU_SUB, 1'b1, 1'b0, "sub_t4");

    opcode = 4'h7; flag_c = 1'b1;
    cyc(0, 3'd0, F0, 1'b0, 1'b0, "jc1_t0");
    cyc(0, 3'd1, F1, 1'b0, 1'b0, "jc1_t1");
    cyc(0, 3'd2, IR_OUT | PC_LOAD, 1'b1, 1'b0, "jc1_t2");

    // Carry high during fetch, low in T2: only the T2 value counts.
    cyc(0, 3'd0, F0, 1'b0, 1'b0, "jc0_t0");
    cyc(0, 3'd1, F1, 1'b0, 1'b0, "jc0_t1");
    flag_c = 1'b0;
    cyc(0, 3'd2, NONE, 1'b1, 1'b0, "jc0_t2");

    opcode = 4'h8; flag_c = 1'b1; flag_z = 1'b1;
    cyc(0, 3'd0, F0, 1'b0, 1'b0, "jz_t0");
    cyc(0, 3'd1, F1, 1'b0, 1'b0, "jz_t1");
    cyc(0, 3'd2, IR_OUT | PC_LOAD, 1'b1, 1'b0, "jz_t2");
    flag_z = 1'b0;

    opcode = 4'h4;
    cyc(0, 3'd0, F0, 1'b0, 1'b0, "sta_t0");
    cyc(0, 3'd1, F1, 1'b0, 1'b0, "sta_t1");
    cyc(0, 3'd2, IR_OUT | MAR_LOAD, 1'b0, 1'b0, "sta_t2");
    cyc(0, 3'd3, REG_A_OUT | RAM_IN, 1'b1, 1'b0, "sta_t3");

    opcode = 4'h6;
    cyc(0, 3'd0, F0, 1'b0, 1'b0, "jmp_t0");
    cyc(0, 3'd1, F1, 1'b0, 1'b0, "jmp_t1");
    cyc(0, 3'd2, IR_OUT | PC_LOAD, 1'b1, 1'b0, "jmp_t2");

    opcode = 4'hE;
    cyc(0, 3'd0, F0, 1'b0, 1'b0, "out_t0");
    cyc(0, 3'd1, F1, 1'b0, 1'b0, "out_t1");
    cyc(0, 3'd2, REG_A_OUT | OUT_REG_LOAD, 1'b1, 1'b0, "out_t2");

    opcode = 4'h9;
    cyc(0, 3'd0, F0, 1'b0, 1'b0, "undef_t0");
    cyc(0, 3'd1, F1, 1'b1, 1'b0, "undef_t1");

    opcode = 4'h2;
    cyc(0, 3'd0, F0, 1'b0, 1'b0, "pause_t0");
    cyc(0, 3'd1, F1, 1'b0, 1'b0, "pause_t1");
    cyc(0, 3'd2, IR_OUT | MAR_LOAD, 1'b0, 1'b0, "pause_t2");
    run = 1'b0;
    for (int i = 0; i < 3; i++) cyc(0, 3'd3, NONE, 1'b0, 1'b0, "paused_t3");
    run = 1'b1;
    cyc(0, 3'd3, RAM_OUT | REG_B_LOAD, 1'b0, 1'b0, "resume_t3");
    cyc(0, 3'd4, ALU_OUT | REG_A_LOAD | FLAGS_LOAD, 1'b1, 1'b0, "resume_t4");

    opcode = 4'h1;
    cyc(0, 3'd0, F0, 1'b0, 1'b0, "abort_t0");
    cyc(0, 3'd1, F1, 1'b0, 1'b0, "abort_t1");
    cyc(0, 3'd2, IR_OUT | MAR_LOAD, 1'b0, 1'b0, "abort_t2");
    rst_n = 1'b0; #2; rst_n = 1'b1;
    cyc(0, 3'd0, F0, 1'b0, 1'b0, "abort_restart");
    cyc(0, 3'd1, F1, 1'b0, 1'b0, "abort_next");

    opcode = 4'h5;
    cyc(0, 3'd2, IR_OUT | REG_A_LOAD, 1'b1, 1'b0, "ldi_t2");

    opcode = 4'hF;
    cyc(0, 3'd0, F0, 1'b0, 1'b0, "hlt_t0");
    cyc(0, 3'd1, F1, 1'b0, 1'b0, "hlt_t1");
    cyc(0, 3'd2, NONE, 1'b1, 1'b0, "hlt_t2");
    opcode = 4'h1;
    for (int i = 0; i < 20; i++) cyc(0, 3'd0, NONE, 1'b0, 1'b1, "halted");
    rst_n = 1'b0;
    cyc(0, 3'd0, NONE, 1'b0, 1'b0, "hlt_reset");
    rst_n = 1'b1; opcode = 4'h0;
    cyc(0, 3'd0, F0, 1'b0, 1'b0, "nop_t0");
    cyc(0, 3'd1, F1, 1'b1, 1'b0, "nop_t1");
    cyc(0, 3'd0, F0, 1'b0, 1'b0, "nop_wrap");

    rst_n = 1'b0;
    cyc(1, 3'd0, NONE, 1'b0, 1'b0, "full_reset");
    rst_n = 1'b1; opcode = 4'h5;
    cyc(1, 3'd0, F0, 1'b0, 1'b0, "full_t0");
    cyc(1, 3'd1, F1, 1'b0, 1'b0, "full_t1");
    cyc(1, 3'd2, IR_OUT | REG_A_LOAD, 1'b1, 1'b0, "full_t2");
    cyc(1, 3'd3, NONE, 1'b0, 1'b0, "full_t3");
    cyc(1, 3'd4, NONE, 1'b0, 1'b0, "full_t4");
    cyc(1, 3'd5, NONE, 1'b0, 1'b0, "full_t5");
    cyc(1, 3'd0, F0, 1'b0, 1'b0, "full_wrap");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
